// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and types for the ctrl_pipeline control-bundle pipeline.
// Opcode and ALUOp encodings mirror the main decoder; fwd selects drive the EX operand muxes.
package ctrl_pipe_pkg;

  localparam int CP_REG_ADDR_W = 5;
  localparam int CP_ALUOP_W    = 2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic mem_read;
    logic branch;
    logic mem_to_reg;
    logic reg_write;
    logic alu_src;
    logic reg_dst;
    logic mem_to_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_forward_unit.sv
// Combinational hazard detection for the ID instruction and, when CTRL_PIPE_FORWARD_EN
// is defined, the EX operand forwarding selects.
module hazard_forward_unit
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = CP_REG_ADDR_W
) (
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic                  i_mem_valid,
  input  logic                  i_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_mem_dest,
`ifdef CTRL_PIPE_FORWARD_EN
  input  logic [REG_ADDR_W-1:0] i_ex_rs,
  input  logic                  i_wb_valid,
  input  logic                  i_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] i_wb_dest,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b,
`else
  input  logic                  i_ex_reg_write,
  input  logic [REG_ADDR_W-1:0] i_ex_dest,
`endif
  output logic                  o_hazard
);

  // A stage can supply src only if it really writes a non-zero register equal to src.
  function automatic logic src_hit(input logic v, input logic we,
                                   input logic [REG_ADDR_W-1:0] dest,
                                   input logic [REG_ADDR_W-1:0] src);
    return v && we && (dest != '0) && (dest == src);
  endfunction

  logic w_load_use;

  assign w_load_use = i_ex_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                      ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

`ifdef CTRL_PIPE_FORWARD_EN
  assign o_hazard = i_id_valid && w_load_use;

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    o_fwd_a = FWD_RF;
    o_fwd_b = FWD_RF;
    if (src_hit(i_mem_valid, i_mem_reg_write, i_mem_dest, i_ex_rs))
      o_fwd_a = FWD_EXMEM;
    else if (src_hit(i_wb_valid, i_wb_reg_write, i_wb_dest, i_ex_rs))
      o_fwd_a = FWD_MEMWB;
    if (src_hit(i_mem_valid, i_mem_reg_write, i_mem_dest, i_ex_rt))
      o_fwd_b = FWD_EXMEM;
    else if (src_hit(i_wb_valid, i_wb_reg_write, i_wb_dest, i_ex_rt))
      o_fwd_b = FWD_MEMWB;
  end
`else
  logic w_raw;

  assign w_raw = src_hit(i_ex_valid,  i_ex_reg_write,  i_ex_dest,  i_id_rs) ||
                 src_hit(i_ex_valid,  i_ex_reg_write,  i_ex_dest,  i_id_rt) ||
                 src_hit(i_mem_valid, i_mem_reg_write, i_mem_dest, i_id_rs) ||
                 src_hit(i_mem_valid, i_mem_reg_write, i_mem_dest, i_id_rt);

  assign o_hazard = i_id_valid && (w_load_use || w_raw);
`endif

endmodule

// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers with stall, bubble and flush generation.
// Define CTRL_PIPE_FORWARD_EN to add fwd_a/fwd_b outputs; then only load-use stalls.
module ctrl_pipeline
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = CP_REG_ADDR_W,
  parameter int ALUOP_W    = CP_ALUOP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_MemRead,
  input  logic                  id_Branch,
  input  logic                  id_MemToReg,
  input  logic                  id_RegWrite,
  input  logic                  id_ALUSrc,
  input  logic                  id_RegDst,
  input  logic                  id_MemToWrite,
  input  logic [ALUOP_W-1:0]    id_ALUOp,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  ex_valid,
  output logic                  ex_ALUSrc,
  output logic                  ex_RegDst,
  output logic [ALUOP_W-1:0]    ex_ALUOp,
  output logic                  mem_valid,
  output logic                  mem_MemRead,
  output logic                  mem_MemToWrite,
  output logic                  mem_Branch,
  output logic                  wb_valid,
  output logic                  wb_MemToReg,
  output logic                  wb_RegWrite,
`ifdef CTRL_PIPE_FORWARD_EN
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
`endif
  output logic [REG_ADDR_W-1:0] wb_dest
);

  logic                  w_hazard, w_flush, w_stall, w_id_we;
  logic [REG_ADDR_W-1:0] w_id_dest_sel, w_id_dest;
  ctrl_t                 w_id_ctrl;
  logic [ALUOP_W-1:0]    w_id_alu_op;

  logic                  r_ex_valid;
  ctrl_t                 r_ex_ctrl;
  logic [ALUOP_W-1:0]    r_ex_alu_op;
  logic [REG_ADDR_W-1:0] r_ex_rt, r_ex_dest;

  logic                  r_mem_valid, r_mem_mem_read, r_mem_branch;
  logic                  r_mem_mem_to_reg, r_mem_reg_write, r_mem_mem_to_write;
  logic [REG_ADDR_W-1:0] r_mem_dest;

  logic                  r_wb_valid, r_wb_mem_to_reg, r_wb_reg_write;
  logic [REG_ADDR_W-1:0] r_wb_dest;

  // A write to $0 is a no-op, so it is stripped here and never looks like a producer.
  assign w_id_dest_sel = id_RegDst ? id_rd : id_rt;
  assign w_id_we       = id_valid && id_RegWrite && (w_id_dest_sel != '0);
  assign w_id_dest     = w_id_we ? w_id_dest_sel : '0;

  // Write-path controls of non-writing instructions are zeroed so decoder don't-cares stay out.
  always_comb begin
    w_id_ctrl   = CTRL_BUBBLE;
    w_id_alu_op = '0;
    if (id_valid) begin
      w_id_ctrl.mem_read     = id_MemRead;
      w_id_ctrl.branch       = id_Branch;
      w_id_ctrl.alu_src      = id_ALUSrc;
      w_id_ctrl.mem_to_write = id_MemToWrite;
      w_id_alu_op            = id_ALUOp;
    end
    w_id_ctrl.reg_write  = w_id_we;
    w_id_ctrl.reg_dst    = w_id_we && id_RegDst;
    w_id_ctrl.mem_to_reg = w_id_we && id_MemToReg;
  end

  assign w_flush    = branch_taken;
  assign w_stall    = w_hazard && !branch_taken;
  assign pc_write   = !w_stall;
  assign ifid_write = !w_stall;
  assign ifid_flush = w_flush;

  // NOTE: pipeline state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || w_flush || w_stall) begin
      r_ex_valid  <= 1'b0;
      r_ex_ctrl   <= CTRL_BUBBLE;
      r_ex_alu_op <= '0;
      r_ex_rt     <= '0;
      r_ex_dest   <= '0;
    end else begin
      r_ex_valid  <= id_valid;
      r_ex_ctrl   <= w_id_ctrl;
      r_ex_alu_op <= w_id_alu_op;
      r_ex_rt     <= id_valid ? id_rt : '0;
      r_ex_dest   <= w_id_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_mem_valid        <= 1'b0;
      r_mem_mem_read     <= 1'b0;
      r_mem_branch       <= 1'b0;
      r_mem_mem_to_reg   <= 1'b0;
      r_mem_reg_write    <= 1'b0;
      r_mem_mem_to_write <= 1'b0;
      r_mem_dest         <= '0;
    end else begin
      r_mem_valid        <= r_ex_valid;
      r_mem_mem_read     <= r_ex_ctrl.mem_read;
      r_mem_branch       <= r_ex_ctrl.branch;
      r_mem_mem_to_reg   <= r_ex_ctrl.mem_to_reg;
      r_mem_reg_write    <= r_ex_ctrl.reg_write;
      r_mem_mem_to_write <= r_ex_ctrl.mem_to_write;
      r_mem_dest         <= r_ex_dest;
    end
  end

  // MEM/WB keeps advancing on a flush so the resolving branch itself retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid      <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_dest       <= '0;
    end else begin
      r_wb_valid      <= r_mem_valid;
      r_wb_mem_to_reg <= r_mem_mem_to_reg;
      r_wb_reg_write  <= r_mem_reg_write;
      r_wb_dest       <= r_mem_dest;
    end
  end

`ifdef CTRL_PIPE_FORWARD_EN
  logic [REG_ADDR_W-1:0] r_ex_rs;

  always_ff @(posedge clk) begin
    if (rst || w_flush || w_stall) r_ex_rs <= '0;
    else                           r_ex_rs <= id_valid ? id_rs : '0;
  end
`endif

  hazard_forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .i_id_valid      (id_valid),
    .i_id_rs         (id_rs),
    .i_id_rt         (id_rt),
    .i_ex_valid      (r_ex_valid),
    .i_ex_mem_read   (r_ex_ctrl.mem_read),
    .i_ex_rt         (r_ex_rt),
    .i_mem_valid     (r_mem_valid),
    .i_mem_reg_write (r_mem_reg_write),
    .i_mem_dest      (r_mem_dest),
`ifdef CTRL_PIPE_FORWARD_EN
    .i_ex_rs         (r_ex_rs),
    .i_wb_valid      (r_wb_valid),
    .i_wb_reg_write  (r_wb_reg_write),
    .i_wb_dest       (r_wb_dest),
    .o_fwd_a         (fwd_a),
    .o_fwd_b         (fwd_b),
`else
    .i_ex_reg_write  (r_ex_ctrl.reg_write),
    .i_ex_dest       (r_ex_dest),
`endif
    .o_hazard        (w_hazard)
  );

  assign ex_valid       = r_ex_valid;
  assign ex_ALUSrc      = r_ex_ctrl.alu_src;
  assign ex_RegDst      = r_ex_ctrl.reg_dst;
  assign ex_ALUOp       = r_ex_alu_op;
  assign mem_valid      = r_mem_valid;
  assign mem_MemRead    = r_mem_mem_read;
  assign mem_MemToWrite = r_mem_mem_to_write;
  assign mem_Branch     = r_mem_branch;
  assign wb_valid       = r_wb_valid;
  assign wb_MemToReg    = r_wb_mem_to_reg;
  assign wb_RegWrite    = r_wb_reg_write;
  assign wb_dest        = r_wb_dest;

endmodule
